// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types: S-box, round constants, word/block typedefs.
package aes_pkg;

    localparam int NUM_ROUNDS_AES128 = 10;
    localparam int WORD_LEN          = 32;

    typedef logic [WORD_LEN-1:0] word_t;
    typedef logic [127:0]        block_t;

    typedef enum logic {ST_IDLE, ST_EMIT} ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Entry 0 is unused; rounds 1..10 index directly.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
        return (r <= 4'd10) ? RCON[r] : 8'h00;
    endfunction

endpackage

// File: rtl/key_subword.sv
// Combinational SubWord: one shared-table S-box lookup per byte of a 32-bit word.
module key_subword
    import aes_pkg::*;
(
    input  word_t word_in,
    output word_t word_out
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign word_out[8*i +: 8] = sbox_lookup(word_in[8*i +: 8]);
    end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule emitting round keys 0..NUM_ROUNDS on a valid/ready stream.
// Optional round-key bank with read port is compiled in when KEY_BANK_EN is defined.
module key_expansion
    import aes_pkg::*;
#(
    parameter int DATA_LEN   = 128,
    parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid_in,
    input  logic [DATA_LEN-1:0] key_in,
    output logic                key_ready,
    output logic                round_key_valid,
    input  logic                round_key_ready,
    output logic [DATA_LEN-1:0] round_key_out,
    output logic [3:0]          round_idx,
    output logic                done
`ifdef KEY_BANK_EN
    ,
    input  logic [3:0]          rd_idx,
    output logic [DATA_LEN-1:0] rd_key,
    output logic                bank_full
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_t state;
    word_t     w0, w1, w2, w3;
    word_t     rot_w, sub_w, temp_w;
    word_t     n0, n1, n2, n3;
    block_t    next_key;
    logic      accept;
    logic      xfer;

    assign accept = key_valid_in && key_ready;
    assign xfer   = round_key_valid && round_key_ready;

    // Next round key derived combinationally from the key currently on the output.
    assign {w0, w1, w2, w3} = round_key_out;
    assign rot_w = {w3[23:0], w3[31:24]};

    key_subword u_subword (
        .word_in  (rot_w),
        .word_out (sub_w)
    );

    assign temp_w   = sub_w ^ {rcon_lookup(round_idx + 4'd1), 24'h0};
    assign n0       = w0 ^ temp_w;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            key_ready       <= 1'b1;
            round_key_valid <= 1'b0;
            round_key_out   <= '0;
            round_idx       <= 4'd0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        round_key_out   <= key_in;
                        round_idx       <= 4'd0;
                        key_ready       <= 1'b0;
                        round_key_valid <= 1'b1;
                        state           <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (xfer) begin
                        if (round_idx == LAST_IDX) begin
                            // Last key stays on the bus; only the index rewinds.
                            round_idx       <= 4'd0;
                            round_key_valid <= 1'b0;
                            key_ready       <= 1'b1;
                            done            <= 1'b1;
                            state           <= ST_IDLE;
                        end else begin
                            round_key_out <= next_key;
                            round_idx     <= round_idx + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef KEY_BANK_EN
    logic [DATA_LEN-1:0] bank [NUM_ROUNDS+1];

    always_ff @(posedge clk) begin
        if (xfer) begin
            bank[round_idx] <= round_key_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full <= 1'b0;
        end else if (accept) begin
            bank_full <= 1'b0;
        end else if (xfer && round_idx == LAST_IDX) begin
            bank_full <= 1'b1;
        end
    end

    assign rd_key = (rd_idx <= LAST_IDX) ? bank[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion against a GF(2^8)-arithmetic key-schedule model.
module tb_key_expansion;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid_in;
    logic [127:0] key_in;
    logic         key_ready;
    logic         round_key_valid;
    logic         round_key_ready;
    logic [127:0] round_key_out;
    logic [3:0]   round_idx;
    logic         done;
`ifdef KEY_BANK_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         bank_full;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] ref_keys [11];
    logic [127:0] captured [11];

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_IDX1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_IDX10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_IDX10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    key_expansion dut (
        .clk             (clk),
        .reset           (reset),
        .key_valid_in    (key_valid_in),
        .key_in          (key_in),
        .key_ready       (key_ready),
        .round_key_valid (round_key_valid),
        .round_key_ready (round_key_ready),
        .round_key_out   (round_key_out),
        .round_idx       (round_idx),
        .done            (done)
`ifdef KEY_BANK_EN
        ,
        .rd_idx          (rd_idx),
        .rd_key          (rd_key),
        .bank_full       (bank_full)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: S-box from GF(2^8) inverse plus affine map, Rcon from xtime.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] s = 8'h01;
        for (int i = 0; i < 254; i++) s = gmul(s, a);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] v = 8'h01;
        for (int i = 1; i < r; i++) v = xtime(v);
        return v;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rcon_ref(i / 4), 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic offer_key(input logic [127:0] k);
        int waited = 0;
        while (key_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("key_ready_before_offer", key_ready, 1);
        key_valid_in = 1'b1;
        key_in       = k;
        @(negedge clk);
        key_valid_in = 1'b0;
    endtask

    task automatic collect(input logic [127:0] k, input bit rand_rdy, input int stall_at,
                           input int stall_len, input int busy_at, input int reset_at,
                           input bit b2b, input logic [127:0] next_key);
        int e = 0;
        int cyc = 0;
        int stalled = 0;
        bit rdy;
        expand(k);
        while (e <= 10 && cyc < 300) begin
            check($sformatf("valid[%0d]", e), round_key_valid, 1);
            check($sformatf("idx[%0d]", e), round_idx, e);
            check($sformatf("key[%0d]", e), round_key_out, ref_keys[e]);
            captured[e] = round_key_out;
            if (e == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_mid_valid", round_key_valid, 0);
                check("rst_mid_key_ready", key_ready, 1);
                check("rst_mid_idx", round_idx, 0);
                check("rst_mid_key", round_key_out, 0);
                check("rst_mid_done", done, 0);
                return;
            end
            rdy = 1'b1;
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
            if (e == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            if (busy_at >= 0 && e == busy_at) begin
                key_valid_in = 1'b1;
                key_in       = '0;
                check("busy_key_ready", key_ready, 0);
            end else if (busy_at >= 0 && e == busy_at + 1) begin
                key_valid_in = 1'b0;
            end
            if (b2b && e == 0) begin
                key_valid_in = 1'b1;
                key_in       = next_key;
            end
            round_key_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) e++;
        end
        round_key_ready = 1'b1;
        check("schedule_complete", e, 11);
        check("done_pulse", done, 1);
        check("done_valid", round_key_valid, 0);
        check("done_key_ready", key_ready, 1);
        check("done_idx", round_idx, 0);
        check("done_key_hold", round_key_out, ref_keys[10]);
        @(negedge clk);
        if (b2b) key_valid_in = 1'b0;
        check("done_clear", done, 0);
        check("post_done_valid", round_key_valid, b2b);
    endtask

    initial begin
        reset           = 1'b1;
        key_valid_in    = 1'b0;
        key_in          = '0;
        round_key_ready = 1'b1;
`ifdef KEY_BANK_EN
        rd_idx          = 4'd0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_key_ready", key_ready, 1);
        check("rst_valid", round_key_valid, 0);
        check("rst_key", round_key_out, 0);
        check("rst_idx", round_idx, 0);
        check("rst_done", done, 0);

        // FIPS-197 A.1 with the consumer always ready.
        offer_key(KEY_A1);
        collect(KEY_A1, 0, -1, 0, -1, -1, 0, '0);
        check("a1_idx0", captured[0], KEY_A1);
        check("a1_idx1", captured[1], A1_IDX1);
        check("a1_idx10", captured[10], A1_IDX10);
`ifdef KEY_BANK_EN
        rd_idx = 4'd1;
        #1 check("bank_rd1", rd_key, A1_IDX1);
        rd_idx = 4'd10;
        #1 check("bank_rd10", rd_key, A1_IDX10);
        rd_idx = 4'd11;
        #1 check("bank_rd11", rd_key, 0);
        check("bank_full_set", bank_full, 1);
        @(negedge clk);
`endif

        // Backpressure at idx4 for three cycles.
        offer_key(KEY_A1);
`ifdef KEY_BANK_EN
        check("bank_full_clear", bank_full, 0);
`endif
        collect(KEY_A1, 0, 4, 3, -1, -1, 0, '0);

        // Zero key offered while busy is ignored, then accepted afterwards.
        offer_key(KEY_A1);
        collect(KEY_A1, 0, -1, 0, 2, -1, 0, '0);
        check("busy_a1_idx10", captured[10], A1_IDX10);
        offer_key('0);
        collect('0, 0, -1, 0, -1, -1, 0, '0);
        check("zero_idx10", captured[10], Z_IDX10);

        // Reset mid-schedule, then a fresh key restarts from idx0.
        begin
            logic [127:0] k1;
            logic [127:0] k2;
            k1 = {$urandom, $urandom, $urandom, $urandom};
            offer_key(k1);
            collect(k1, 0, -1, 0, -1, 6, 0, '0);
            k2 = {$urandom, $urandom, $urandom, $urandom};
            offer_key(k2);
            collect(k2, 0, -1, 0, -1, -1, 0, '0);
        end

        // Back-to-back: second key accepted in the done cycle.
        begin
            logic [127:0] k1;
            logic [127:0] k2;
            k1 = {$urandom, $urandom, $urandom, $urandom};
            k2 = {$urandom, $urandom, $urandom, $urandom};
            offer_key(k1);
            collect(k1, 0, -1, 0, -1, -1, 1, k2);
            collect(k2, 0, -1, 0, -1, -1, 0, '0);
        end

        // Random keys under random backpressure.
        for (int n = 0; n < 4; n++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            offer_key(k);
            collect(k, 1, -1, 0, -1, -1, 0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
